// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap/interrupt sequencing and a registered fetch redirect.
// Define CSR_VECTORED_TRAP_EN to make mtvec MODE writable and vector interrupts.
module csr_trap_unit #(
    parameter logic [63:0] HARTID = 64'd0,
    parameter int          CNT_W  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wsrc,
    output logic [63:0] csr_rdata,
    input  logic        commit_valid,
    input  logic        exc_valid,
    input  logic [5:0]  exc_cause,
    input  logic [63:0] exc_pc,
    input  logic [63:0] exc_tval,
    input  logic        int_take,
    input  logic [63:0] int_pc,
    input  logic        mret_valid,
    input  logic        irq_msip,
    input  logic        irq_mtip,
    input  logic        irq_meip,
    output logic        int_req,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    input  logic        redirect_ready,
    output logic [1:0]  priv_out,
    output logic [63:0] mstatus_out,
    output logic [63:0] mtvec_out,
    output logic [63:0] mepc_out,
    output logic [63:0] mcause_out,
    output logic [63:0] mtval_out,
    output logic [63:0] mip_out,
    output logic [63:0] mie_out,
    output logic [63:0] mscratch_out,
    output logic [63:0] mcycle_out,
    output logic [63:0] minstret_out
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;

    typedef enum logic {S_IDLE, S_REDIRECT} state_t;
    state_t state;

    logic [1:0]       priv;
    logic             st_mie;
    logic             st_mpie;
    logic [1:0]       st_mpp;
    logic [63:0]      mtvec, mepc, mcause, mtval, mie, mscratch;
    logic [2:0]       irq_q;
    logic [CNT_W-1:0] mcycle, minstret;

    logic [63:0] mstatus_val, mip_val, mcycle_ext, minstret_ext;
    logic [63:0] pending, csr_wdata, trap_target, mtvec_next;
    logic [5:0]  int_code;
    logic        idle, exc_acc, int_acc, mret_acc, csr_we;

    assign mstatus_val = {51'd0, st_mpp, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
    assign mip_val     = {52'd0, irq_q[2], 3'd0, irq_q[1], 3'd0, irq_q[0], 3'd0};

    always_comb begin
        mcycle_ext                = '0;
        minstret_ext              = '0;
        mcycle_ext[CNT_W-1:0]     = mcycle;
        minstret_ext[CNT_W-1:0]   = minstret;
    end

    assign pending = mip_val & mie & 64'h888;
    assign int_req = (|pending) && (st_mie || priv != 2'd3);

    // Highest-priority pending source: MEI, then MSI, then MTI.
    always_comb begin
        int_code = 6'd7;
        if (pending[11])
            int_code = 6'd11;
        else if (pending[3])
            int_code = 6'd3;
    end

    assign idle     = (state == S_IDLE);
    assign exc_acc  = idle && exc_valid;
    assign int_acc  = idle && !exc_valid && int_take && int_req;
    assign mret_acc = idle && !exc_valid && !int_acc && mret_valid;
    assign csr_we   = (csr_op != OP_NONE) && !exc_acc && !int_acc && !mret_acc;

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = mstatus_val;
            A_MIE:      csr_rdata = mie;
            A_MTVEC:    csr_rdata = mtvec;
            A_MSCRATCH: csr_rdata = mscratch;
            A_MEPC:     csr_rdata = mepc;
            A_MCAUSE:   csr_rdata = mcause;
            A_MTVAL:    csr_rdata = mtval;
            A_MIP:      csr_rdata = mip_val;
            A_MCYCLE:   csr_rdata = mcycle_ext;
            A_MINSTRET: csr_rdata = minstret_ext;
            A_MHARTID:  csr_rdata = HARTID;
            default:    csr_rdata = '0;
        endcase
    end

    always_comb begin
        csr_wdata = csr_rdata & ~csr_wsrc;
        if (csr_op == OP_RW)
            csr_wdata = csr_wsrc;
        else if (csr_op == OP_RS)
            csr_wdata = csr_rdata | csr_wsrc;
    end

`ifdef CSR_VECTORED_TRAP_EN
    // MODE is WARL: only direct (0) and vectored (1) are retained.
    assign mtvec_next = {csr_wdata[63:2], 1'b0, csr_wdata[1:0] == 2'b01};

    always_comb begin
        trap_target = {mtvec[63:2], 2'b00};
        if (!exc_valid && mtvec[1:0] == 2'b01)
            trap_target = {mtvec[63:2], 2'b00} + {56'd0, int_code, 2'b00};
    end
`else
    assign mtvec_next  = {csr_wdata[63:2], 2'b00};
    assign trap_target = {mtvec[63:2], 2'b00};
`endif

    // Trap entry and MRET pre-empt a same-cycle CSR write; counters write-over-increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            priv     <= 2'd3;
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            st_mpp   <= 2'd0;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mie      <= '0;
            mscratch <= '0;
            irq_q    <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            irq_q  <= {irq_meip, irq_mtip, irq_msip};
            mcycle <= mcycle + CNT_W'(1);
            if (commit_valid)
                minstret <= minstret + CNT_W'(1);
            if (exc_acc || int_acc) begin
                mepc    <= (exc_acc ? exc_pc : int_pc) & ~64'h3;
                mcause  <= exc_acc ? {58'd0, exc_cause} : {1'b1, 57'd0, int_code};
                mtval   <= exc_acc ? exc_tval : 64'd0;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                st_mpp  <= priv;
                priv    <= 2'd3;
            end else if (mret_acc) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                priv    <= st_mpp;
                st_mpp  <= 2'd0;
            end else if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie  <= csr_wdata[3];
                        st_mpie <= csr_wdata[7];
                        st_mpp  <= csr_wdata[12:11];
                    end
                    A_MIE:      mie      <= csr_wdata & 64'h888;
                    A_MTVEC:    mtvec    <= mtvec_next;
                    A_MSCRATCH: mscratch <= csr_wdata;
                    A_MEPC:     mepc     <= csr_wdata & ~64'h3;
                    A_MCAUSE:   mcause   <= csr_wdata;
                    A_MTVAL:    mtval    <= csr_wdata;
                    A_MCYCLE:   mcycle   <= csr_wdata[CNT_W-1:0];
                    A_MINSTRET: minstret <= csr_wdata[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_acc || int_acc) begin
                        state          <= S_REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= trap_target;
                    end else if (mret_acc) begin
                        state          <= S_REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= mepc;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= S_IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign priv_out     = priv;
    assign mstatus_out  = mstatus_val;
    assign mtvec_out    = mtvec;
    assign mepc_out     = mepc;
    assign mcause_out   = mcause;
    assign mtval_out    = mtval;
    assign mip_out      = mip_val;
    assign mie_out      = mie;
    assign mscratch_out = mscratch;
    assign mcycle_out   = mcycle_ext;
    assign minstret_out = minstret_ext;
endmodule
